// File: rtl/alu_exec_unit.sv
// Single-issue ALU execution unit: one-cycle ops plus a shift-add multiplier,
// with a valid/ready request side and a held result until the consumer takes it.
module alu_exec_unit #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             op_err,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a request transfers on a rising edge with in_valid & in_ready
  // (IDLE only); a result transfers on a rising edge with out_valid & out_ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_MULT = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  localparam logic [SHW:0] MULT_STEPS = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE    = (SHW+1)'(1);

  state_t           state_q;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] op_res_d;

  assign in_ready    = (state_q == S_IDLE) && !rst;
  assign dbg_state_o = state_q;

  always_comb begin
    op_res_d = '0;
    case (alu_control)
      OP_ADD:  op_res_d = src_a + src_b;
      OP_XOR:  op_res_d = src_a ^ src_b;
      OP_SUB:  op_res_d = src_a - src_b;
      OP_SLT:  op_res_d = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLL:  op_res_d = src_a << src_b[SHW-1:0];
      OP_SRL:  op_res_d = src_a >> src_b[SHW-1:0];
      default: op_res_d = '0;
    endcase
    // Multiplicand is pre-shifted, so only the low WIDTH product bits are kept.
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      op_err    <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (alu_control == OP_MULT) begin
              state_q  <= S_MULT;
              cnt_q    <= '0;
              acc_q    <= '0;
              mcand_q  <= src_a;
              mplier_q <= src_b;
            end else begin
              state_q   <= S_DONE;
              out_valid <= 1'b1;
              result    <= op_res_d;
              zero      <= (op_res_d == '0);
              op_err    <= (alu_control == OP_ILL);
            end
          end
        end
        S_MULT: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_d;
          if (cnt_d == MULT_STEPS) begin
            state_q   <= S_DONE;
            out_valid <= 1'b1;
            result    <= acc_d;
            zero      <= (acc_d == '0);
            op_err    <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q   <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits (power of two, 8..32).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  unit can accept a request.
REQ-007 alu_control  input  3  operation code: 000 add, 001 xor, 010 sub, 011 slt, 100 sll, 101 srl, 110 mult, 111 illegal.
REQ-008 src_a  input  WIDTH  operand A.
REQ-009 src_b  input  WIDTH  operand B; bits [SHW-1:0] are the shift amount for sll/srl.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero  output  1  registered, equals (result == 0); consumed for beq.
REQ-014 op_err  output  1  registered, high with result when alu_control was 111.

Function
REQ-015 SHALL implement FSM states IDLE, MULT, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; accept occurs on an edge where in_valid & in_ready.
REQ-017 On accept, alu_control, src_a, src_b SHALL be captured; later input changes SHALL not affect the operation.
REQ-018 Non-mult codes: result computed on the accept edge, state -> DONE, out_valid=1 in the following cycle (latency 1).
REQ-019 add/sub SHALL wrap modulo 2^WIDTH; carry/borrow discarded.
REQ-020 slt SHALL compare src_a < src_b as two's-complement signed; result = 1 or 0 zero-extended.
REQ-021 sll/srl SHALL shift src_a by src_b[SHW-1:0], zero-filling; upper src_b bits ignored.
REQ-022 xor SHALL be bitwise src_a ^ src_b.
REQ-023 Code 111 SHALL produce result=0, zero=1, op_err=1, latency 1; all other codes op_err=0.
REQ-024 mult: accept edge -> MULT with iteration counter 0, accumulator 0; one shift-add step per edge (examine multiplier LSB, add shifted multiplicand, shift).
REQ-025 After exactly WIDTH MULT edges, state -> DONE; out_valid=1 WIDTH cycles after accept; result = low WIDTH bits of the unsigned product.
REQ-026 In DONE, result/zero/op_err/out_valid SHALL hold stable until an edge with out_ready=1, then state -> IDLE, out_valid=0.
REQ-027 out_ready while not in DONE SHALL be ignored; in_valid while not IDLE SHALL be ignored (no queuing).
REQ-028 Back-to-back throughput: one non-mult op per 2 cycles when out_ready is held 1.
REQ-029 Counter SHALL be SHW+1 bits wide and SHALL not wrap before DONE.

Reset
REQ-030 rst=1 on an edge SHALL force state IDLE, out_valid=0, result=0, zero=1, op_err=0, counter=0, accumulator=0, regardless of state (including mid-MULT or DONE).
REQ-031 in_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst deasserts; an in-flight operation is discarded, no out_valid produced.

Verification (WIDTH=16)
REQ-032 add 0xFFFF+0x0002, out_ready=1 -> out_valid 1 cycle after accept, result=0x0001, zero=0; sub 0x1234-0x1234 -> result=0x0000, zero=1.
REQ-033 slt 0xFFFF vs 0x0001 -> result=0x0001; slt 0x0001 vs 0xFFFF -> 0x0000; sll 0x0001 by src_b=0x0013 -> shift 3, result=0x0008; srl 0x8000 by 15 -> 0x0001.
REQ-034 mult 0x0123*0x0045 -> out_valid exactly 16 cycles after accept, result=0x4E6F; mult 0xFFFF*0xFFFF -> 0x0001; in_ready=0 throughout.
REQ-035 Backpressure: out_ready=0 for 5 cycles in DONE -> result/out_valid stable, in_valid pulses ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-036 rst=1 at MULT iteration 7 -> next cycle out_valid=0, result=0, in_ready=1 after deassert; subsequent xor 0xAAAA^0x5555 -> 0xFFFF.
REQ-037 Code 111 with src_a=0x1234 -> result=0x0000, zero=1, op_err=1 for one transaction; next add clears op_err.
